key_press_detector: RTL and testbench
=====================================

// Module: key_press_detector
// PURPOSE
//  Consumes the pixel stream produced by the camera capture stage (one RGB333 pixel per valid
//  beat, with x/y coordinates and frame markers). Counts dark pixels per piano key inside a
//  horizontal key band and thresholds the count once per frame. Debounces the result across
//  frames and presents a registered pressed-key mask to the note/sound stage and the debug LEDs.
// PARAMETERS
//  NKEYS    8    number of keys, laid side by side left to right
//  X0       0    x of left edge of key 0
//  KEY_W    80   key width in pixels; key k spans [X0+k*KEY_W, X0+(k+1)*KEY_W)
//  Y_TOP    400  first row of key band (inclusive)
//  Y_BOT    440  last row of key band (exclusive)
//  LUMA_TH  6    pixel is dark when r+g+b < LUMA_TH
//  CNT_TH   200  raw press when a key's dark count >= CNT_TH
//  DEBOUNCE 3    consecutive agreeing frames needed to flip a mask bit (1..15)
// PORTS
//  clk          in   1      pixel clock (same clock as camera stage)
//  rst          in   1      synchronous reset, active low
//  frame_start  in   1      1-cycle pulse, start of frame
//  frame_end    in   1      1-cycle pulse, end of frame
//  pix_valid    in   1      pix_* valid this cycle
//  pix_x        in   10     pixel column
//  pix_y        in   10     pixel row
//  pix_data     in   9      {r[2:0],g[2:0],b[2:0]}
//  key_mask     out  NKEYS  debounced pressed keys, bit k = key k
//  key_raw      out  NKEYS  undebounced per-frame result (debug)
//  key_changed  out  1      1-cycle pulse when key_mask changes
//  frame_cnt    out  8      evaluated frames, wraps 255->0
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): state IDLE; all counters, key_mask, key_raw, key_changed,
//    frame_cnt = 0. Reset mid-frame discards everything; no evaluation follows.
//  - FSM IDLE -> ACCUM on frame_start (all per-key counters cleared that cycle).
//    ACCUM -> EVAL on frame_end; EVAL -> UPDATE -> IDLE unconditionally.
//  - ACCUM: on pix_valid with Y_TOP<=pix_y<Y_BOT, pixel in key k, and r+g+b<LUMA_TH
//    (5-bit sum), cnt[k] += 1. cnt is 16-bit, saturates at 0xFFFF.
//    Pixels outside all keys/band are ignored. Key index by range compare; no divider.
//  - A pixel with pix_valid in the same cycle as frame_end is counted.
//  - frame_start while in ACCUM: the frame is aborted, counters cleared, and ACCUM
//    continues. No evaluation occurs.
//  - frame_start and frame_end in the same cycle in ACCUM: frame_end wins and the frame is
//    evaluated. frame_start is dropped.
//  - frame_end in IDLE is ignored. frame_start in EVAL/UPDATE is dropped, and that frame is
//    skipped. Upstream guarantees >=3 cycles between frame_end and the next frame_start.
//  - EVAL (cycle t+1 after frame_end at t): key_raw[k] <= (cnt[k] >= CNT_TH).
//    frame_cnt += 1.
//  - UPDATE (t+2), per key, 4-bit agree counter ag[k]:
//    - if key_raw[k]==key_mask[k]: ag[k] <= 0.
//    - else: ag[k] += 1; when ag[k]+1 == DEBOUNCE, key_mask[k] flips and ag[k] <= 0.
//  - key_changed = 1 in the cycle after UPDATE iff any mask bit flipped; otherwise 0.
//  - Latency: frame_end at t -> key_raw valid t+2, key_mask/key_changed valid t+3
//    (registered outputs).
//  - Outputs hold their values between evaluations. They are never X after reset.
// TESTING
//  1. Reset: drive rst=0 for 2 cycles with random pix -> all outputs 0, FSM IDLE.
//  2. Press key 2: 3 frames with 40 rows x 10 dark px (0x000) in x=160..169, y=400..439
//     (400 dark px/frame) -> key_raw=0x04 each frame. key_mask=0x04 and key_changed pulse
//     exactly once, 3 cycles after 3rd frame_end. frame_cnt=3.
//  3. Threshold edge: key 0 gets exactly 200 dark px -> raw bit 1; 199 -> 0.
//     Pixel 0x1FF (luma 21) and dark px at y=399 or y=440 -> not counted.
//  4. Debounce glitch: key_mask=0x04, then 2 frames with key 2 bright, then 1 dark ->
//     key_mask stays 0x04, no key_changed. 3 bright frames -> key_mask=0x00 with pulse.
//  5. Abort/collisions: frame_start mid-frame after 150 dark px in key 1, then 100 more dark
//     px + frame_end -> raw bit1=0. Also check a last pixel counted when coincident with
//     frame_end.
//  6. Mid-frame reset after 300 dark px in key 5, then a clean empty frame -> key_raw=0,
//     frame_cnt=1. frame_cnt wraps from 255 to 0 after 256 frames.

Source files
------------

// File: rtl/key_press_detector_if.sv
// rtl/key_press_detector_if.sv - pixel stream bundle from the camera capture stage
interface key_press_detector_if;
    logic       frame_start;
    logic       frame_end;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [8:0] pix_data;

    modport master (output frame_start, frame_end, pix_valid, pix_x, pix_y, pix_data);
    modport slave  (input  frame_start, frame_end, pix_valid, pix_x, pix_y, pix_data);
endinterface

// File: rtl/key_press_detector.sv
// rtl/key_press_detector.sv - per-key dark pixel counting, per-frame threshold and debounced key mask
module key_press_detector #(
    parameter int NKEYS    = 8,
    parameter int X0       = 0,
    parameter int KEY_W    = 80,
    parameter int Y_TOP    = 400,
    parameter int Y_BOT    = 440,
    parameter int LUMA_TH  = 6,
    parameter int CNT_TH   = 200,
    parameter int DEBOUNCE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    key_press_detector_if.slave  pix,
    output logic [NKEYS-1:0]     key_mask,
    output logic [NKEYS-1:0]     key_raw,
    output logic                 key_changed,
    output logic [7:0]           frame_cnt
);
    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, UPDATE} state_t;

    state_t           state;
    logic [15:0]      cnt [NKEYS];
    logic [3:0]       ag  [NKEYS];
    logic [NKEYS-1:0] hit;
    logic [NKEYS-1:0] flip;
    logic [4:0]       luma;
    logic             dark;
    logic             in_band;

    assign luma    = 5'(pix.pix_data[8:6]) + 5'(pix.pix_data[5:3]) + 5'(pix.pix_data[2:0]);
    assign dark    = luma < 5'(LUMA_TH);
    assign in_band = (pix.pix_y >= 10'(Y_TOP)) && (pix.pix_y < 10'(Y_BOT));

    // Each key owns a fixed column range, so membership is two constant compares.
    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        localparam int LO = X0 + k * KEY_W;
        localparam int HI = LO + KEY_W;
        assign hit[k]  = pix.pix_valid && in_band && dark &&
                         ({2'b00, pix.pix_x} >= 12'(LO)) && ({2'b00, pix.pix_x} < 12'(HI));
        assign flip[k] = (key_raw[k] != key_mask[k]) && ((ag[k] + 4'd1) == 4'(DEBOUNCE));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            key_mask    <= '0;
            key_raw     <= '0;
            key_changed <= 1'b0;
            frame_cnt   <= 8'd0;
            for (int k = 0; k < NKEYS; k++) begin
                cnt[k] <= 16'd0;
                ag[k]  <= 4'd0;
            end
        end else begin
            key_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (pix.frame_start) begin
                        for (int k = 0; k < NKEYS; k++) cnt[k] <= 16'd0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    // A restart without a coincident frame_end aborts the frame in progress.
                    if (pix.frame_start && !pix.frame_end) begin
                        for (int k = 0; k < NKEYS; k++) cnt[k] <= 16'd0;
                    end else begin
                        for (int k = 0; k < NKEYS; k++)
                            if (hit[k] && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
                    end
                    if (pix.frame_end) state <= EVAL;
                end
                EVAL: begin
                    for (int k = 0; k < NKEYS; k++) key_raw[k] <= (cnt[k] >= 16'(CNT_TH));
                    frame_cnt <= frame_cnt + 8'd1;
                    state     <= UPDATE;
                end
                UPDATE: begin
                    for (int k = 0; k < NKEYS; k++)
                        ag[k] <= (key_raw[k] == key_mask[k] || flip[k]) ? 4'd0 : ag[k] + 4'd1;
                    key_mask    <= key_mask ^ flip;
                    key_changed <= |flip;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_press_detector.sv
// tb/tb_key_press_detector.sv - directed self-checking bench for key_press_detector
module tb_key_press_detector;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key_mask, key_raw, frame_cnt;
    logic       key_changed;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         pulse_cnt = 0;

    key_press_detector_if pix_if ();

    key_press_detector dut (
        .clk         (clk),
        .rst         (rst),
        .pix         (pix_if),
        .key_mask    (key_mask),
        .key_raw     (key_raw),
        .key_changed (key_changed),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_changed === 1'b1) pulse_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        pix_if.frame_start = 1'b0;
        pix_if.frame_end   = 1'b0;
        pix_if.pix_valid   = 1'b0;
        pix_if.pix_x       = 10'd0;
        pix_if.pix_y       = 10'd0;
        pix_if.pix_data    = 9'h1FF;
    endtask

    task automatic frame_begin;
        pix_if.frame_start = 1'b1;
        tick();
        pix_if.frame_start = 1'b0;
    endtask

    task automatic send_px(input int x, input int y, input logic [8:0] d);
        pix_if.pix_valid = 1'b1;
        pix_if.pix_x     = 10'(x);
        pix_if.pix_y     = 10'(y);
        pix_if.pix_data  = d;
        tick();
        pix_if.pix_valid = 1'b0;
    endtask

    task automatic send_block(input int x0, input int ncols, input int y0, input int n, input logic [8:0] d);
        for (int i = 0; i < n; i++) send_px(x0 + i % ncols, y0 + i / ncols, d);
    endtask

    // Raises frame_end (with whatever else the caller left on the bus) and samples the results.
    task automatic end_frame(output logic [7:0] raw, output logic [7:0] mask, output logic chg, output logic chg_next);
        pix_if.frame_end = 1'b1;
        tick();
        clear_inputs();
        tick();
        raw = key_raw;
        tick();
        mask = key_mask;
        chg  = key_changed;
        tick();
        chg_next = key_changed;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_if.pix_valid   = 1'($urandom);
            pix_if.frame_start = 1'($urandom);
            pix_if.frame_end   = 1'($urandom);
            pix_if.pix_x       = 10'($urandom);
            pix_if.pix_y       = 10'($urandom);
            pix_if.pix_data    = 9'($urandom);
            tick();
        end
        n_cmp++; if (key_mask !== 8'h00) begin n_bad++; $display("FAIL reset_mask: got %h expected 00", key_mask); end
        n_cmp++; if (key_raw !== 8'h00) begin n_bad++; $display("FAIL reset_raw: got %h expected 00", key_raw); end
        n_cmp++; if (key_changed !== 1'b0) begin n_bad++; $display("FAIL reset_changed: got %b expected 0", key_changed); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_fcnt: got %0d expected 0", frame_cnt); end
        clear_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_press_key2;
        logic [7:0] raw, mask;
        logic       chg, chg_n;
        logic [7:0] exp_mask [3] = '{8'h00, 8'h00, 8'h04};
        logic       exp_chg  [3] = '{1'b0, 1'b0, 1'b1};
        for (int f = 0; f < 3; f++) begin
            frame_begin();
            send_block(160, 10, 400, 400, 9'h000);
            end_frame(raw, mask, chg, chg_n);
            n_cmp++; if (raw !== 8'h04) begin n_bad++; $display("FAIL press_raw f%0d: got %h expected 04", f, raw); end
            n_cmp++; if (mask !== exp_mask[f]) begin n_bad++; $display("FAIL press_mask f%0d: got %h expected %h", f, mask, exp_mask[f]); end
            n_cmp++; if (chg !== exp_chg[f]) begin n_bad++; $display("FAIL press_chg f%0d: got %b expected %b", f, chg, exp_chg[f]); end
            n_cmp++; if (chg_n !== 1'b0) begin n_bad++; $display("FAIL press_chg_len f%0d: got %b expected 0", f, chg_n); end
        end
        n_cmp++; if (frame_cnt !== 8'd3) begin n_bad++; $display("FAIL press_fcnt: got %0d expected 3", frame_cnt); end
        n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL press_pulses: got %0d expected 1", pulse_cnt); end
    endtask

    task automatic test_debounce;
        logic [7:0] raw, mask;
        logic       chg, chg_n;
        logic       dark_f   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_raw  [6] = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_mask [6] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00};
        logic       exp_chg  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int f = 0; f < 6; f++) begin
            frame_begin();
            if (dark_f[f]) send_block(160, 10, 400, 400, 9'h000);
            else           send_block(160, 10, 400, 20, 9'h1FF);
            end_frame(raw, mask, chg, chg_n);
            n_cmp++; if (raw !== exp_raw[f]) begin n_bad++; $display("FAIL deb_raw f%0d: got %h expected %h", f, raw, exp_raw[f]); end
            n_cmp++; if (mask !== exp_mask[f]) begin n_bad++; $display("FAIL deb_mask f%0d: got %h expected %h", f, mask, exp_mask[f]); end
            n_cmp++; if (chg !== exp_chg[f]) begin n_bad++; $display("FAIL deb_chg f%0d: got %b expected %b", f, chg, exp_chg[f]); end
        end
        n_cmp++; if (pulse_cnt !== 2) begin n_bad++; $display("FAIL deb_pulses: got %0d expected 2", pulse_cnt); end
        n_cmp++; if (frame_cnt !== 8'd9) begin n_bad++; $display("FAIL deb_fcnt: got %0d expected 9", frame_cnt); end
    endtask

    // Key 0 gets 199 pure-black pixels plus one boundary-luma pixel, surrounded by non-counting distractors.
    task automatic test_threshold;
        logic [7:0] raw, mask;
        logic       chg, chg_n;
        logic [8:0] last_px [2] = '{9'h091, 9'h092};
        logic [7:0] exp_raw [2] = '{8'h01, 8'h00};
        for (int f = 0; f < 2; f++) begin
            frame_begin();
            send_block(0, 10, 400, 199, 9'h000);
            send_px(9, 419, last_px[f]);
            send_px(0, 420, 9'h1FF);
            send_px(1, 399, 9'h000);
            send_px(2, 440, 9'h000);
            send_px(80, 420, 9'h000);
            end_frame(raw, mask, chg, chg_n);
            n_cmp++; if (raw !== exp_raw[f]) begin n_bad++; $display("FAIL thr_raw f%0d: got %h expected %h", f, raw, exp_raw[f]); end
            n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL thr_mask f%0d: got %h expected 00", f, mask); end
        end
    endtask

    task automatic test_abort_collide;
        logic [7:0] raw, mask;
        logic       chg, chg_n;
        frame_begin();
        send_block(80, 10, 400, 150, 9'h000);
        frame_begin();
        send_block(80, 10, 400, 100, 9'h000);
        end_frame(raw, mask, chg, chg_n);
        n_cmp++; if (raw !== 8'h00) begin n_bad++; $display("FAIL abort_raw: got %h expected 00", raw); end
        frame_begin();
        send_block(80, 10, 400, 199, 9'h000);
        pix_if.frame_start = 1'b1;
        pix_if.pix_valid   = 1'b1;
        pix_if.pix_x       = 10'd159;
        pix_if.pix_y       = 10'd439;
        pix_if.pix_data    = 9'h000;
        end_frame(raw, mask, chg, chg_n);
        n_cmp++; if (raw !== 8'h02) begin n_bad++; $display("FAIL collide_raw: got %h expected 02", raw); end
        n_cmp++; if (frame_cnt !== 8'd13) begin n_bad++; $display("FAIL collide_fcnt: got %0d expected 13", frame_cnt); end
        pix_if.frame_end = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (frame_cnt !== 8'd13) begin n_bad++; $display("FAIL idle_end_fcnt: got %0d expected 13", frame_cnt); end
    endtask

    task automatic test_midframe_reset;
        logic [7:0] raw, mask;
        logic       chg, chg_n;
        frame_begin();
        send_block(400, 10, 400, 300, 9'h000);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (key_raw !== 8'h00) begin n_bad++; $display("FAIL mreset_raw: got %h expected 00", key_raw); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL mreset_fcnt: got %0d expected 0", frame_cnt); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL mreset_noeval: got %0d expected 0", frame_cnt); end
        frame_begin();
        end_frame(raw, mask, chg, chg_n);
        n_cmp++; if (raw !== 8'h00) begin n_bad++; $display("FAIL clean_raw: got %h expected 00", raw); end
        n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL clean_fcnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_wrap;
        logic [7:0] raw, mask;
        logic       chg, chg_n;
        for (int f = 0; f < 254; f++) begin
            frame_begin();
            end_frame(raw, mask, chg, chg_n);
        end
        n_cmp++; if (frame_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d expected 255", frame_cnt); end
        frame_begin();
        end_frame(raw, mask, chg, chg_n);
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_0: got %0d expected 0", frame_cnt); end
        n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL wrap_mask: got %h expected 00", mask); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_press_key2();
        test_debounce();
        test_threshold();
        test_abort_collide();
        test_midframe_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
